// File: rtl/dom_pkg.sv
// Shared helpers for DOM-masked GF(2^N) multipliers:
// randomness indexing and sizing.
package dom_pkg;

   localparam int MAX_SHARES = 8;

   function automatic int rand_idx(input int i, input int j);
      if (i < j) return i + (j * (j - 1)) / 2;
      else return j + (i * (i - 1)) / 2;
   endfunction

   function automatic int rand_width(input int n, input int s);
      return (n * s * (s - 1)) / 2;
   endfunction

endpackage

// File: rtl/gf2_mul.sv
// Combinational GF(2^N) multiplier, polynomial basis.
// Reduction by x^2+x+1 (N=2) or x^4+x+1 (N=4).
module gf2_mul #(
   parameter int N = 2
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_p
);

   // both supported polynomials have low part x+1
   localparam logic [N-1:0] RED = N'(3);

   logic [N-1:0] w_acc;
   logic [N-1:0] w_sh;

   always_comb begin
      w_acc = '0;
      w_sh  = i_a;
      for (int k = 0; k < N; k++) begin
         if (i_b[k]) w_acc = w_acc ^ w_sh;
         w_sh = {w_sh[N-2:0], 1'b0}
              ^ (w_sh[N-1] ? RED : '0);
      end
   end

   assign o_p = w_acc;

endmodule

// File: rtl/shared_mul_gf2n_pipe.sv
// Flow-controlled DOM-masked GF(2^N) multiplier.
// Define SHARED_MUL_OUTREG_EN for a registered output stage.
module shared_mul_gf2n_pipe
   import dom_pkg::*;
#(
   parameter int N      = 2,
   parameter int SHARES = 2
) (
   input  logic                  ClkxCI,
   input  logic                  RstxBI,
   input  logic                  InValidxSI,
   output logic                  InReadyxSO,
   input  logic [SHARES*N-1:0]   _XxDI,
   input  logic [SHARES*N-1:0]   _YxDI,
   input  logic [rand_width(N, SHARES)-1:0] _ZxDI,
   output logic                  OutValidxSO,
   input  logic                  OutReadyxSI,
   output logic [SHARES*N-1:0]   _QxDO
);

   logic [N-1:0] w_prod [SHARES][SHARES];
   logic [N-1:0] w_term [SHARES][SHARES];
   logic [N-1:0] r_term [SHARES][SHARES];
   logic [SHARES*N-1:0] w_qp;
   logic r_s1v;
   logic w_acc;
   logic w_s1_go;

   for (genvar i = 0; i < SHARES; i++) begin : g_i
      for (genvar j = 0; j < SHARES; j++) begin : g_j
         gf2_mul #(.N(N)) u_mul (
            .i_a(_XxDI[i*N +: N]),
            .i_b(_YxDI[j*N +: N]),
            .o_p(w_prod[i][j])
         );
         if (i == j) begin : g_dom
            assign w_term[i][j] = w_prod[i][j];
         end else begin : g_cross
            localparam int RI = rand_idx(i, j);
            assign w_term[i][j] =
               w_prod[i][j] ^ _ZxDI[RI*N +: N];
         end
      end
   end

   assign w_acc = InValidxSI && InReadyxSO;

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         r_term <= '{default: '0};
         r_s1v  <= 1'b0;
      end else begin
         if (w_acc) r_term <= w_term;
         if (w_acc) r_s1v <= 1'b1;
         else if (w_s1_go) r_s1v <= 1'b0;
      end
   end

   // compression strictly after the term registers
   always_comb begin
      w_qp = '0;
      for (int i = 0; i < SHARES; i++) begin
         for (int j = 0; j < SHARES; j++) begin
            w_qp[i*N +: N] = w_qp[i*N +: N]
                           ^ r_term[i][j];
         end
      end
   end

`ifdef SHARED_MUL_OUTREG_EN
   logic r_s2v;
   logic [SHARES*N-1:0] r_q;
   logic w_s2_rdy;

   assign w_s2_rdy = !r_s2v || OutReadyxSI;
   assign w_s1_go  = r_s1v && w_s2_rdy;

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         r_s2v <= 1'b0;
         r_q   <= '0;
      end else if (w_s1_go) begin
         r_s2v <= 1'b1;
         r_q   <= w_qp;
      end else if (OutReadyxSI) begin
         r_s2v <= 1'b0;
      end
   end

   assign OutValidxSO = r_s2v;
   assign _QxDO       = r_q;
`else
   assign w_s1_go     = r_s1v && OutReadyxSI;
   assign OutValidxSO = r_s1v;
   assign _QxDO       = w_qp;
`endif

   assign InReadyxSO = !r_s1v || w_s1_go;

endmodule

// File: tb/tb_shared_mul_gf2n_pipe.sv
// Directed bench for shared_mul_gf2n_pipe, two configurations:
// N=2/SHARES=2 table vectors and N=4/SHARES=3 streams.
module tb_shared_mul_gf2n_pipe;

`ifdef SHARED_MUL_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic a_iv, a_irdy, a_ov, a_ordy;
   logic [3:0] a_x, a_y, a_q;
   logic [1:0] a_z;

   logic b_iv, b_irdy, b_ov, b_ordy;
   logic [11:0] b_x, b_y, b_z, b_q;

   shared_mul_gf2n_pipe #(.N(2), .SHARES(2)) u_a (
      .ClkxCI(clk), .RstxBI(rst_n),
      .InValidxSI(a_iv), .InReadyxSO(a_irdy),
      ._XxDI(a_x), ._YxDI(a_y), ._ZxDI(a_z),
      .OutValidxSO(a_ov), .OutReadyxSI(a_ordy),
      ._QxDO(a_q)
   );

   shared_mul_gf2n_pipe #(.N(4), .SHARES(3)) u_b (
      .ClkxCI(clk), .RstxBI(rst_n),
      .InValidxSI(b_iv), .InReadyxSO(b_irdy),
      ._XxDI(b_x), ._YxDI(b_y), ._ZxDI(b_z),
      .OutValidxSO(b_ov), .OutReadyxSI(b_ordy),
      ._QxDO(b_q)
   );

   int n_chk = 0;
   int n_err = 0;
   int n_out = 0;
   int mode = 0;
   logic have_s0 = 1'b0;
   logic varied = 1'b0;
   logic [3:0] first_s0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [1:0] x0, x1, y0, y1, z, q;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // GF(4) by hand table, x^2 = x + 1
   function automatic logic [1:0] gf4(input logic [1:0] a,
                                      input logic [1:0] b);
      if (a == 0 || b == 0) return 2'd0;
      if (a == 1) return b;
      if (b == 1) return a;
      if (a == 2 && b == 2) return 2'd3;
      if (a == 3 && b == 3) return 2'd2;
      return 2'd1;
   endfunction

   // GF(16): carry-less product, then reduce mod x^4+x+1
   function automatic logic [3:0] gf16(input logic [3:0] a,
                                       input logic [3:0] b);
      logic [6:0] p;
      p = '0;
      for (int i = 0; i < 4; i++)
         if (b[i]) p = p ^ (7'(a) << i);
      for (int k = 6; k >= 4; k--)
         if (p[k]) p = p ^ (7'(5'b10011) << (k - 4));
      return p[3:0];
   endfunction

   function automatic logic [3:0] fold(input logic [11:0] v);
      return v[3:0] ^ v[7:4] ^ v[11:8];
   endfunction

   task automatic set_b_rand();
      b_x = 12'($urandom);
      b_y = 12'($urandom);
      b_z = 12'($urandom);
   endtask

   // one cycle of instance B: score output, log accept, advance
   task automatic cyc_b();
      logic [3:0] e;
      if (b_ov && b_ordy) begin
         n_out++;
         if (exp_q.size() == 0) begin
            chk("b_spurious_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("b_unshared", 32'(fold(b_q)), 32'(e));
            if (mode == 1) begin
               chk("rnd_q_const", 32'(fold(b_q)), 9);
               if (!have_s0) begin
                  first_s0 = b_q[3:0];
                  have_s0 = 1'b1;
               end else if (b_q[3:0] != first_s0) begin
                  varied = 1'b1;
               end
            end
            if (mode == 2)
               chk("zero_q", 32'(fold(b_q)), 0);
         end
      end
      if (b_iv && b_irdy)
         exp_q.push_back(gf16(fold(b_x), fold(b_y)));
      @(negedge clk);
   endtask

   task automatic drain_b();
      b_iv = 1'b0;
      b_ordy = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() > 0; c++)
         cyc_b();
      chk("b_drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int lat, sent, bub, acc, chg, o0;
      logic started, have;
      logic [11:0] held;

      vt[0] = '{2'd1, 2'd0, 2'd3, 2'd0, 2'd2, 2'd3};
      vt[1] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1};
      vt[2] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0};
      vt[3] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3};
      vt[4] = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3};
      vt[5] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd1};
      vt[6] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2};
      vt[7] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};

      rst_n = 1'b0;
      a_iv = 0; a_ordy = 1; a_x = 0; a_y = 0; a_z = 0;
      b_iv = 0; b_ordy = 1; b_x = 0; b_y = 0; b_z = 0;
      #2;
      chk("rst_a_valid", a_ov, 0);
      chk("rst_a_ready", a_irdy, 1);
      chk("rst_a_q", a_q, 0);
      chk("rst_b_valid", b_ov, 0);
      chk("rst_b_q", b_q, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // table vectors, single transfers on the N=2 instance
      for (int v = 0; v < 8; v++) begin
         a_x = {vt[v].x1, vt[v].x0};
         a_y = {vt[v].y1, vt[v].y0};
         a_z = vt[v].z;
         a_iv = 1'b1;
         chk("a_in_ready", a_irdy, 1);
         @(negedge clk);
         a_iv = 1'b0;
         lat = 1;
         while (!a_ov && lat < 8) begin
            @(negedge clk);
            lat++;
         end
         chk("a_latency", lat, LAT);
         chk("a_unshared", 32'(a_q[1:0] ^ a_q[3:2]),
             32'(vt[v].q));
         chk("a_share0", 32'(a_q[1:0]),
             32'(gf4(vt[v].x0, vt[v].y0)
               ^ gf4(vt[v].x0, vt[v].y1) ^ vt[v].z));
         chk("a_share1", 32'(a_q[3:2]),
             32'(gf4(vt[v].x1, vt[v].y1)
               ^ gf4(vt[v].x1, vt[v].y0) ^ vt[v].z));
         @(negedge clk);
         chk("a_valid_one_cycle", a_ov, 0);
      end

      // 100-deep back-to-back stream on the N=4 instance
      n_out = 0; sent = 0; bub = 0; started = 0;
      b_ordy = 1'b1;
      for (int c = 0; c < 140; c++) begin
         if (sent >= 100 && exp_q.size() == 0) break;
         if (b_ov) started = 1'b1;
         else if (started && exp_q.size() > 0) bub++;
         if (sent < 100) begin
            set_b_rand();
            b_iv = 1'b1;
         end else begin
            b_iv = 1'b0;
         end
         if (b_iv && b_irdy) sent++;
         cyc_b();
      end
      b_iv = 1'b0;
      chk("stream_count", n_out, 100);
      chk("stream_bubbles", bub, 0);

      // backpressure for 5 cycles with input held valid
      drain_b();
      set_b_rand();
      b_iv = 1'b1;
      b_ordy = 1'b0;
      acc = 0; chg = 0; have = 0; held = '0;
      for (int c = 0; c < 5; c++) begin
         logic a;
         a = b_iv && b_irdy;
         if (a) acc++;
         if (b_ov) begin
            if (!have) begin
               held = b_q;
               have = 1'b1;
            end else if (b_q !== held) begin
               chg++;
            end
         end
         cyc_b();
         if (a) set_b_rand();
      end
      chk("bp_in_ready_low", b_irdy, 0);
      chk("bp_accepts", acc, LAT);
      chk("bp_out_valid", b_ov, 1);
      chk("bp_q_stable", chg, 0);
      o0 = n_out;
      drain_b();
      for (int c = 0; c < 3; c++) cyc_b();
      chk("bp_release_outputs", n_out - o0, LAT);

      // fixed operands, random Z: unshared constant 9
      mode = 1;
      n_out = 0;
      b_x = {4'hC, 4'h5, 4'h3};
      b_y = {4'hF, 4'h8, 4'h1};
      for (int c = 0; c < 50; c++) begin
         b_z = 12'($urandom);
         b_iv = 1'b1;
         cyc_b();
      end
      drain_b();
      mode = 0;
      chk("rnd_count", n_out, 50);
      chk("rnd_shares_vary", varied, 1);

      // zero X with random shares
      mode = 2;
      n_out = 0;
      for (int c = 0; c < 30; c++) begin
         set_b_rand();
         b_x[11:8] = b_x[3:0] ^ b_x[7:4];
         b_iv = 1'b1;
         cyc_b();
      end
      drain_b();
      mode = 0;
      chk("zero_count", n_out, 30);

      // reset asserted mid-cycle while busy
      b_ordy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         set_b_rand();
         b_iv = 1'b1;
         cyc_b();
      end
      chk("pre_rst_valid", b_ov, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_b_valid", b_ov, 0);
      chk("arst_b_q", b_q, 0);
      chk("arst_b_ready", b_irdy, 1);
      b_iv = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_ready", b_irdy, 1);
      o0 = n_out;
      for (int c = 0; c < 4; c++) cyc_b();
      chk("post_rst_no_output", n_out - o0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/shared_mul_gf2n_pipe.md
# shared_mul_gf2n_pipe

Flow-controlled, d-th order DOM-masked multiplier over GF(2^N) with a generic share count. It is the next generation of the shared GF(2) multiplier, with a parametrised field width and a valid/ready handshake so that S-box datapaths can stall. It has an asynchronous reset and an optional output register stage. It sits inside the masked S-box between the shared inversion stages and the linear maps.

## Interface
Parameters:
- N, 2, field width in bits (2 or 4); the product is exactly what gf2_mul #(N) computes.
- SHARES, 2, number of Boolean shares; must be ≥ 2.

Ports:
- ClkxCI  in  1  clock; rising-edge.
- RstxBI  in  1  reset; asynchronous, active-low.
- InValidxSI  in  1  input operands and randomness valid.
- InReadyxSO  out  1  block accepts input this cycle.
- _XxDI  in  SHARES*N  shares of X; share i is at bits [i*N +: N].
- _YxDI  in  SHARES*N  shares of Y; same packing as X.
- _ZxDI  in  N*SHARES*(SHARES-1)/2  fresh randomness; word r is at bits [r*N +: N].
- OutValidxSO  out  1  result valid.
- OutReadyxSI  in  1  downstream accepts the result.
- _QxDO  out  SHARES*N  shares of Q = X·Y; same packing as X.

## Operation
- Accept: an input is accepted when InValidxSI && InReadyxSO.
- Products: for each domain pair (i,j), the term is p_ij = gf2_mul(X_i, Y_j).
  - Domain term, i = j: p_ii.
  - Cross term, i < j: p_ij ^ Z[i + j(j-1)/2].
  - Cross term, i > j: p_ij ^ Z[j + i(i-1)/2].
- Stage-1 registers: all SHARES² terms are captured in stage-1 registers on accept. X, Y and Z are sampled only on accept; no randomness is consumed while stalled.
- Compression: Q_i is the XOR over j of the registered terms (i,j). Compression uses only registered values and is never done before the register.
- Stage-1 valid flag s1v:
  - set on accept;
  - cleared when the stage is drained and there is no new accept;
  - held, with its data, while the downstream is stalled.
- Ready chain: InReadyxSO = !s1v || (the next stage accepts). The path is combinational from OutReadyxSI; OutReadyxSI must not depend combinationally on InReadyxSO.
- Throughput: one result per cycle with no bubbles while OutReadyxSI = 1.
- Reset (RstxBI = 0):
  - all valid flags and all term/data registers go to 0 immediately;
  - OutValidxSO = 0 and _QxDO = 0;
  - InReadyxSO = 1 once the stage is empty;
  - in-flight data is discarded, with no partial output.
- Unshared correctness: XOR over i of Q_i equals gf2_mul(XOR of X_i, XOR of Y_i) for any Z.

## Timing
Without SHARED_MUL_OUTREG_EN:
- Latency 1: a result accepted at edge k is on OutValidxSO/_QxDO after edge k.
- _QxDO is the XOR tree of the stage-1 registers (combinational output).

With SHARED_MUL_OUTREG_EN:
- Latency 2: stage 2 registers the compressed Q_i together with its valid flag s2v.
- s1 → s2 transfer when s1v && (!s2v || OutReadyxSI).
- OutValidxSO = s2v, and _QxDO is driven directly from flops.

Common rules:
- Simultaneous drain and accept in the same cycle replaces the stage contents with no gap.
- When OutValidxSO && !OutReadyxSI, _QxDO is held stable until accepted.

## Configuration
- Macro SHARED_MUL_OUTREG_EN.
- Defined: adds a second registered stage (glitch-free, registered outputs, latency 2, two entries in flight).
- Undefined: single stage, latency 1, one entry in flight.
- Both variants have the same interface and the same handshake semantics.

## Structure
- Package dom_pkg holds:
  - function rand_idx(i,j), returning the Z word index for a pair;
  - function rand_width(N,SHARES) = N*SHARES*(SHARES-1)/2;
  - a constant for the maximum supported SHARES.
- Sub-module: gf2_mul #(N), instantiated SHARES² times. No other sub-modules.

## Test plan
- Reset during activity: feed valid data, pull RstxBI low mid-cycle → OutValidxSO = 0 and _QxDO = 0 asynchronously; after release InReadyxSO = 1 and no stale output appears.
- Single transfer, N=2, SHARES=2: X shares {01,00}, Y shares {11,00}, Z = 10 → after the configured latency, Q0^Q1 = gf2_mul(01,11), with OutValidxSO high for exactly one cycle.
- Back-to-back stream with OutReadyxSI = 1: 100 random operand/Z sets → 100 results in order, one per cycle, with unshared results matching the gf2_mul model.
- Backpressure: hold OutReadyxSI = 0 for 5 cycles with InValidxSI = 1:
  - without the macro, InReadyxSO = 0 after 1 accept;
  - with the macro, InReadyxSO = 0 after 2 accepts;
  - _QxDO stays stable, and on release no result is lost or duplicated.
- Randomness independence: fixed X = 1010, Y = 0110 (N=4, SHARES=3) with 50 random Z values → the unshared Q is constant each time; the individual shares vary with Z.
- Zero operand: X unshared = 0 with random shares and random Z → the unshared Q is 0 for every transfer.
